// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA encoding tables for the instruction encoder and the control decoder.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package mips_isa_pkg;

    // Symbolic request opcodes on the loader interface; 10..15 are illegal
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_ADDI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_J    = 4'd9
    } in_op_e;

    // Primary opcode field, bits [31:26]
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    // R-type function field, bits [5:0]
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // sll $0,$0,0 -- the canonical MIPS no-op
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Program-load sequencing states of the encoder
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    function automatic logic [31:0] rtype_word(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] itype_word(input logic [5:0] opc, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    // Ops that transfer control and therefore own a delay slot
    function automatic logic is_ctrl_xfer(input logic [3:0] op);
        return (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Packs one symbolic request into a 32-bit MIPS word and flags illegal ops.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is consumed.
module mips_instr_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the instruction format and field values for the requested op
    always_comb begin
        word    = NOP_WORD;
        illegal = 1'b0;
        case (op)
            OP_ADD:  word = rtype_word(rs, rt, rd, FUNCT_ADD);
            OP_SUB:  word = rtype_word(rs, rt, rd, FUNCT_SUB);
            OP_AND:  word = rtype_word(rs, rt, rd, FUNCT_AND);
            OP_OR:   word = rtype_word(rs, rt, rd, FUNCT_OR);
            OP_SLT:  word = rtype_word(rs, rt, rd, FUNCT_SLT);
            OP_ADDI: word = itype_word(OPC_ADDI, rs, rt, imm);
            OP_LW:   word = itype_word(OPC_LW, rs, rt, imm);
            OP_SW:   word = itype_word(OPC_SW, rs, rt, imm);
            OP_BEQ:  word = itype_word(OPC_BEQ, rs, rt, imm);
            OP_J:    word = {OPC_J, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Streams symbolic requests as encoded MIPS words to sequential imem addresses.
// Latency: 1 cycle accept-to-out_valid; one word per cycle sustained.
// Backpressure: one-entry output register, in_ready = !out_valid || out_ready.
// Optional build macro MIPS_ENC_DELAY_SLOT_EN inserts a NOP after each BEQ/J.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              start_base_sel,
    input  logic [ADDR_W-1:0] start_base,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_word,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] word_count
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    enc_state_e        state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              err_q, err_d;

    logic              in_ready_c;
    logic              slot_free;
    logic              slot_pend;
    logic              load_en;
    logic [31:0]       load_word;
    logic [31:0]       pack_word;
    logic              pack_illegal;

`ifdef MIPS_ENC_DELAY_SLOT_EN
    // Set when a BEQ/J has been loaded and its delay-slot NOP is still owed
    logic              slot_q, slot_d;
    logic              load_ctrl;
    assign slot_pend = slot_q;
`else
    assign slot_pend = 1'b0;
`endif

    mips_instr_pack u_pack (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // Next-state, request acceptance and output-register loading
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_word_d  = out_word_q;
        next_addr_d = next_addr_q;
        count_d     = count_q;
        err_d       = err_q;
        in_ready_c  = 1'b0;
        load_en     = 1'b0;
        load_word   = NOP_WORD;
`ifdef MIPS_ENC_DELAY_SLOT_EN
        load_ctrl   = 1'b0;
`endif
        // The output slot can take a new word if empty or draining this cycle
        slot_free = !out_valid_q || out_ready;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    next_addr_d = start_base_sel ? start_base : BASE_A;
                    count_d     = '0;
                    err_d       = 1'b0;
                end
            end
            ST_RUN: begin
                if (slot_pend) begin
                    // Delay-slot NOP takes this cycle; the request waits
                    load_en = slot_free;
                end else begin
                    in_ready_c = slot_free;
                    if (in_valid && slot_free) begin
                        if (pack_illegal) begin
                            err_d = 1'b1;
                        end else begin
                            load_en   = 1'b1;
                            load_word = pack_word;
`ifdef MIPS_ENC_DELAY_SLOT_EN
                            load_ctrl = is_ctrl_xfer(in_op);
`endif
                        end
                        if (in_last) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (slot_pend) begin
                    load_en = slot_free;
                end else if (slot_free) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_en) begin
            out_valid_d = 1'b1;
            out_word_d  = load_word;
            out_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + 1'b1;
            count_d     = count_q + 1'b1;
        end
`ifdef MIPS_ENC_DELAY_SLOT_EN
        // A load while a NOP is owed is the NOP itself, which settles the debt
        slot_d = load_ctrl || (slot_q && !load_en);
`endif
    end

    // State and datapath registers; reset discards any pending word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_word_q  <= '0;
            next_addr_q <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_word_q  <= out_word_d;
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

`ifdef MIPS_ENC_DELAY_SLOT_EN
    // Delay-slot debt flag
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= 1'b0;
        end else begin
            slot_q <= slot_d;
        end
    end
`endif

    assign in_ready    = in_ready_c;
    assign out_valid   = out_valid_q;
    assign out_addr    = out_addr_q;
    assign out_word    = out_word_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign err_illegal = err_q;
    assign word_count  = count_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: vector table, directed corners, random load.
// Expected words come from an arithmetic reference encoder and an address/word queue.
// out_ready is driven always-high, random, or by hand depending on the phase.
module tb_mips_instr_encoder;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              start_base_sel;
    logic [ADDR_W-1:0] start_base;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_word;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic [ADDR_W-1:0] word_count;

    always #5 clk = ~clk;

    mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .start_base_sel(start_base_sel),
        .start_base(start_base), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_word(out_word), .busy(busy), .done(done),
        .err_illegal(err_illegal), .word_count(word_count)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
    } exp_t;

    typedef struct {
        int          op;
        int          rs;
        int          rt;
        int          rd;
        int          imm;
        int          tgt;
        logic [31:0] exp_w;
        bit          exp_ill;
    } vec_t;

    int                n_tests = 0;
    int                n_fail  = 0;
    exp_t              exp_q[$];
    logic [ADDR_W-1:0] m_addr;
    logic [ADDR_W-1:0] m_count;
    bit                m_err;
    int                rdy_mode = 0;   // 0 always ready, 1 random, 2 manual
    bit                hold_prev = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       prev_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoder: field values weighted by their bit positions
    function automatic void ref_encode(input longint unsigned op, input longint unsigned rs,
                                       input longint unsigned rt, input longint unsigned rd,
                                       input longint unsigned imm, input longint unsigned tgt,
                                       output logic [31:0] w, output bit ill);
        longint unsigned fn[5];
        longint unsigned opc[4];
        longint unsigned v;
        fn  = '{32, 34, 36, 37, 42};
        opc = '{8, 35, 43, 4};
        ill = 1'b0;
        v   = 0;
        if (op < 5)
            v = rs * 2097152 + rt * 65536 + rd * 2048 + fn[op];
        else if (op < 9)
            v = opc[op - 5] * 67108864 + rs * 2097152 + rt * 65536 + imm;
        else if (op == 9)
            v = 2 * 67108864 + tgt;
        else
            ill = 1'b1;
        w = v[31:0];
    endfunction

    function automatic void push_exp(input logic [31:0] w);
        exp_t e;
        e.addr = m_addr;
        e.word = w;
        exp_q.push_back(e);
        m_addr  = m_addr + 8'd1;
        m_count = m_count + 8'd1;
    endfunction

    // out_ready driver for the automatic modes
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: every handshaken word must be the next expected one,
    // and a stalled word must not change
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                hold_prev = 0;
            end else begin
                if (hold_prev)
                    check("stall hold", {out_valid, out_addr, out_word}, {1'b1, prev_addr, prev_word});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected word: got 0x%0h @%0d, expected none", out_word, out_addr);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("out_word", out_word, e.word);
                        check("out_addr", out_addr, e.addr);
                    end
                end
                hold_prev = out_valid && !out_ready;
                prev_addr = out_addr;
                prev_word = out_word;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input bit sel, input logic [ADDR_W-1:0] base);
        @(negedge clk);
        start = 1'b1;
        start_base_sel = sel;
        start_base = base;
        m_addr  = sel ? base : 8'd0;
        m_count = 8'd0;
        m_err   = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one request; returns how many cycles it waited for in_ready
    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int imm, input int tgt, input bit last, output int waits);
        logic [31:0] w;
        bit          ill;
        waits = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_op     = 4'(op);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_imm    = 16'(imm);
        in_target = 26'(tgt);
        in_last   = last;
        #1;
        while (!in_ready) begin
            waits++;
            if (waits > 200) begin
                check("in_ready timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        ref_encode(op, rs, rt, rd, imm, tgt, w, ill);
        if (ill) begin
            m_err = 1'b1;
        end else begin
            push_exp(w);
`ifdef MIPS_ENC_DELAY_SLOT_EN
            if (op == 8 || op == 9) push_exp(32'h0);
`endif
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            #2;
            if (done) seen = 1;
        end
        check({name, " done seen"}, seen, 1);
        @(negedge clk);
        #2;
        check({name, " done/busy after"}, {done, busy}, 2'b00);
        check({name, " all words out"}, exp_q.size(), 0);
        check({name, " word_count"}, word_count, m_count);
        check({name, " err_illegal"}, err_illegal, m_err);
    endtask

    initial begin
        vec_t vt[12];
        int   wt;

        vt[0]  = '{0,  1,  2,  3, 'hABCD, 'h3FFFFFF, 32'h00221820, 1'b0};
        vt[1]  = '{5,  0,  2, 31, 'h0007, 0,          32'h20020007, 1'b0};
        vt[2]  = '{6,  1,  5,  0, 'h0004, 0,          32'h8C250004, 1'b0};
        vt[3]  = '{1,  4,  5,  6, 0,      0,          32'h00853022, 1'b0};
        vt[4]  = '{13, 3,  3,  3, 'h1234, 'h55,       32'h0,        1'b1};
        vt[5]  = '{2,  31, 31, 31, 0,     0,          32'h03FFF824, 1'b0};
        vt[6]  = '{3,  7,  8,  9, 0,      0,          32'h00E84825, 1'b0};
        vt[7]  = '{4,  2,  3,  1, 0,      0,          32'h0043082A, 1'b0};
        vt[8]  = '{7,  29, 31, 0, 'hFFFC, 0,          32'hAFBFFFFC, 1'b0};
        vt[9]  = '{9,  0,  0,  0, 0,      'h3FFFFFF,  32'h0BFFFFFF, 1'b0};
        vt[10] = '{15, 1,  1,  1, 0,      0,          32'h0,        1'b1};
        vt[11] = '{8,  1,  2,  0, 'hFFFF, 0,          32'h1022FFFF, 1'b0};

        rst = 1'b1; start = 1'b0; start_base_sel = 1'b0; start_base = '0;
        in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm = '0; in_target = '0; in_last = 1'b0;
        m_addr = '0; m_count = '0; m_err = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_addr", out_addr, 0);
        check("rst out_word", out_word, 0);
        check("rst done", done, 0);
        check("rst err", err_illegal, 0);
        check("rst word_count", word_count, 0);
        check("rst busy", busy, 0);
        rst = 1'b0;

        // Vector table in one load, always ready
        do_start(1'b0, 8'd0);
        for (int i = 0; i < 12; i++) begin
            send(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].imm, vt[i].tgt, 1'b0, wt);
            if (vt[i].exp_ill)
                check($sformatf("vec%0d illegal no word", i), out_valid, 0);
            else
                check($sformatf("vec%0d word", i), {out_valid, out_word}, {1'b1, vt[i].exp_w});
            if (i == 0) begin
                check("first addr", out_addr, 0);
                check("first word_count", word_count, 1);
            end
        end
        send(9, 0, 0, 0, 0, 'h10, 1'b1, wt);
        wait_done("table");

        // Back-to-back acceptance
        do_start(1'b0, 8'd0);
        send(5, 0, 2, 0, 7, 0, 1'b0, wt);
        send(6, 1, 5, 0, 4, 0, 1'b1, wt);
        check("b2b LW no wait", wt, 0);
        wait_done("b2b");

        // Backpressure: LW stalled three cycles
        @(negedge clk);
        #1;
        rdy_mode = 2;
        out_ready = 1'b0;
        do_start(1'b0, 8'd0);
        send(6, 1, 5, 0, 4, 0, 1'b0, wt);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            check("bp in_ready low", in_ready, 0);
            check("bp held", {out_valid, out_addr, out_word}, {1'b1, 8'd0, 32'h8C250004});
        end
        @(negedge clk);
        #1;
        out_ready = 1'b1;
        send(0, 1, 2, 3, 0, 0, 1'b1, wt);
        rdy_mode = 0;
        wait_done("backpressure");

        // Illegal between two ADDs, start while busy ignored, J with last
        do_start(1'b0, 8'd0);
        send(0, 1, 2, 3, 0, 0, 1'b0, wt);
        @(negedge clk);
        start = 1'b1; start_base_sel = 1'b1; start_base = 8'd77;
        @(negedge clk);
        start = 1'b0;
        send(12, 1, 2, 3, 0, 0, 1'b0, wt);
        check("illegal sets err", err_illegal, 1);
        send(0, 4, 5, 6, 0, 0, 1'b0, wt);
        send(9, 0, 0, 0, 0, 'h10, 1'b1, wt);
        wait_done("illegal");

        // Address wrap from the top of the space
        do_start(1'b1, 8'd255);
        send(0, 1, 1, 1, 0, 0, 1'b0, wt);
        send(3, 2, 2, 2, 0, 0, 1'b1, wt);
        wait_done("wrap");

        // Illegal op carrying in_last still finishes the load
        do_start(1'b0, 8'd0);
        send(2, 3, 4, 5, 0, 0, 1'b0, wt);
        send(11, 0, 0, 0, 0, 0, 1'b1, wt);
        wait_done("illegal last");

`ifdef MIPS_ENC_DELAY_SLOT_EN
        // BEQ as last request: NOP must follow before completion
        do_start(1'b0, 8'd0);
        send(8, 1, 2, 0, 'hFFFF, 0, 1'b1, wt);
        wait_done("delay slot");
`endif

        // Random load with random backpressure
        rdy_mode = 1;
        do_start(1'b1, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 60; i++) begin
            send($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863),
                 (i == 59), wt);
        end
        wait_done("random");
        rdy_mode = 0;

        // Reset in the middle of a load discards the pending word
        @(negedge clk);
        #1;
        rdy_mode = 2;
        out_ready = 1'b0;
        do_start(1'b0, 8'd0);
        send(0, 1, 2, 3, 0, 0, 1'b0, wt);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst outputs", {out_valid, out_addr, out_word, word_count},
              {1'b0, 8'd0, 32'd0, 8'd0});
        check("midrst status", {in_ready, busy, done, err_illegal}, 4'b0000);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        #2;
        check("after rst idle", {out_valid, busy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
